// File: rtl/router_port_drain.sv
// ---------------------------------------------------------------------------
// router_port_drain
//   Downstream consumer for one router output port. It pulls bytes out of the
//   port FIFO, parses each packet (header, payload, parity), forwards the
//   payload on a valid/ready stream through a 2-entry skid buffer, and
//   flushes a packet whose downstream has stalled. The flush keeps the
//   router's own soft-reset timeout from firing.
//
//   Header byte : [7:2] payload length (0 is treated as 1), [1:0] address.
//   Parity byte : XOR of the header and every payload byte.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-high
//   valid_out   : port FIFO not empty
//   data_out    : FIFO byte, valid the cycle after read_enb was high
//   read_enb    : FIFO read strobe
//   m_data      : payload byte (skid head)
//   m_valid     : m_data valid
//   m_ready     : downstream accepts
//   m_sop       : first payload byte of a packet, qualified by m_valid
//   m_last      : last payload byte of a packet, qualified by m_valid
//   pkt_len     : length of the current packet, loaded when the header returns
//   pkt_done    : one-cycle pulse when a packet completes or is dropped
//   pkt_err     : parity mismatch, valid with pkt_done
//   pkt_drop    : packet was dropped, valid with pkt_done
//   dbg_state_o : current FSM state (IDLE=0 HDR=1 PAY=2 PAR=3 DROP=4)
//
// Stream handshake: a byte moves on every rising edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready, and the head
// entry (m_data/m_sop/m_last) holds steady until it is accepted or the
// packet is dropped.
// ---------------------------------------------------------------------------
module router_port_drain #(
   parameter int STALL_LIMIT = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       valid_out,
   input  logic [7:0] data_out,
   output logic       read_enb,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_sop,
   output logic       m_last,
   output logic [5:0] pkt_len,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic       pkt_drop,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PAY  = 3'd2,
      S_PAR  = 3'd3,
      S_DROP = 3'd4
   } state_t;

   localparam logic [4:0] STALL_MAX = 5'(STALL_LIMIT - 1);

   state_t     state_q, state_d;
   logic       inflight_q;
   logic [6:0] rd_left_q, rd_left_d;
   logic [6:0] pay_cnt_q, pay_cnt_d;
   logic [5:0] len_q, len_d;
   logic [7:0] par_q, par_d;
   logic [4:0] stall_q, stall_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       drop_q, drop_d;

   // Skid entries are {sop, last, data}.
   logic [9:0] skid_mem_q [2];
   logic [1:0] skid_cnt_q;
   logic       skid_rd_q, skid_wr_q;
   logic       push, pop, skid_flush;
   logic [9:0] push_word;

   logic       rd_req;
   logic       reads_left;
   logic [1:0] occ;
   logic       stall_en, stall_cyc, stall_hit;
   logic [5:0] hdr_len;

   assign reads_left = (rd_left_q != 7'd0);
   // Skid entries plus the byte still on its way back from the FIFO.
   assign occ        = skid_cnt_q + {1'b0, inflight_q};
   assign hdr_len    = (data_out[7:2] == 6'd0) ? 6'd1 : data_out[7:2];

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: output (read strobe)
   // ------------------------------------------------------------------
   always_comb begin
      rd_req = 1'b0;
      case (state_q)
         // One idle cycle after pkt_done before the next header read.
         S_IDLE:       rd_req = valid_out & ~done_q;
         S_PAY, S_PAR: rd_req = valid_out & reads_left & (occ < 2'd2);
         S_DROP:       rd_req = valid_out & reads_left;
         // HDR: header is outstanding, nothing else may be read yet.
         default:      rd_req = 1'b0;
      endcase
   end

   // Held low while reset is asserted so no FIFO byte is lost to reset.
   assign read_enb = rd_req & ~reset;

   assign stall_en  = (state_q == S_HDR) || (state_q == S_PAY) || (state_q == S_PAR);
   assign stall_cyc = stall_en & valid_out & ~rd_req;
   // The STALL_LIMIT-th consecutive stalled cycle moves to DROP.
   assign stall_hit = stall_cyc & (stall_q == STALL_MAX);

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (rd_req) state_d = S_HDR;
         S_HDR:  if (inflight_q) state_d = S_PAY;
         S_PAY: begin
            if (stall_hit)                           state_d = S_DROP;
            else if (rd_req && rd_left_q == 7'd1)    state_d = S_PAR;
         end
         S_PAR: begin
            if (inflight_q)     state_d = S_IDLE;
            else if (stall_hit) state_d = S_DROP;
         end
         // rd_left_q==0 here means the final read's byte is returning now.
         S_DROP: if (!reads_left) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Packet datapath
   // ------------------------------------------------------------------
   always_comb begin
      rd_left_d = rd_left_q;
      pay_cnt_d = pay_cnt_q;
      len_d     = len_q;
      par_d     = par_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      drop_d    = 1'b0;
      push      = 1'b0;
      push_word = 10'd0;
      stall_d   = stall_cyc ? stall_q + 5'd1 : 5'd0;

      if (rd_req && (state_q != S_IDLE)) rd_left_d = rd_left_q - 7'd1;

      case (state_q)
         S_HDR: begin
            if (inflight_q) begin
               len_d     = hdr_len;
               rd_left_d = {1'b0, hdr_len} + 7'd1;
               pay_cnt_d = 7'd0;
               par_d     = data_out;
            end
         end
         S_PAY: begin
            if (inflight_q) begin
               pay_cnt_d = pay_cnt_q + 7'd1;
               par_d     = par_q ^ data_out;
               push      = 1'b1;
               push_word = {(pay_cnt_q == 7'd0), (pay_cnt_d == {1'b0, len_q}), data_out};
            end
         end
         S_PAR: begin
            if (inflight_q) begin
               done_d = 1'b1;
               err_d  = ((par_q ^ data_out) != 8'd0);
            end
         end
         S_DROP: begin
            if (!reads_left) begin
               done_d = 1'b1;
               drop_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         rd_left_q  <= 7'd0;
         pay_cnt_q  <= 7'd0;
         len_q      <= 6'd0;
         par_q      <= 8'd0;
         stall_q    <= 5'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         inflight_q <= read_enb;
         rd_left_q  <= rd_left_d;
         pay_cnt_q  <= pay_cnt_d;
         len_q      <= len_d;
         par_q      <= par_d;
         stall_q    <= stall_d;
         done_q     <= done_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
      end
   end

   // ------------------------------------------------------------------
   // 2-entry skid buffer
   // ------------------------------------------------------------------
   assign pop        = m_valid & m_ready;
   // Drop discards whatever payload is still buffered, starting next cycle.
   assign skid_flush = (state_d == S_DROP) && (state_q != S_DROP);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         skid_mem_q[0] <= 10'd0;
         skid_mem_q[1] <= 10'd0;
         skid_cnt_q    <= 2'd0;
         skid_rd_q     <= 1'b0;
         skid_wr_q     <= 1'b0;
      end else if (skid_flush) begin
         skid_cnt_q <= 2'd0;
         skid_rd_q  <= 1'b0;
         skid_wr_q  <= 1'b0;
      end else begin
         if (push) begin
            skid_mem_q[skid_wr_q] <= push_word;
            skid_wr_q             <= ~skid_wr_q;
         end
         if (pop) skid_rd_q <= ~skid_rd_q;
         skid_cnt_q <= skid_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign m_valid     = (skid_cnt_q != 2'd0);
   assign m_data      = skid_mem_q[skid_rd_q][7:0];
   assign m_sop       = m_valid & skid_mem_q[skid_rd_q][9];
   assign m_last      = m_valid & skid_mem_q[skid_rd_q][8];

   assign pkt_len     = len_q;
   assign pkt_done    = done_q;
   assign pkt_err     = err_q;
   assign pkt_drop    = drop_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_port_drain.sv
// ---------------------------------------------------------------------------
// tb_router_port_drain
//   Directed bench for router_port_drain. The bench plays the router FIFO
//   (bytes returned the cycle after read_enb) and the downstream sink, and
//   compares the payload stream and packet status against hand-built
//   packets.
// ---------------------------------------------------------------------------
module tb_router_port_drain;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset;
   logic       valid_out;
   logic [7:0] data_out;
   logic       read_enb;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_sop;
   logic       m_last;
   logic [5:0] pkt_len;
   logic       pkt_done;
   logic       pkt_err;
   logic       pkt_drop;
   logic [2:0] dbg_state;

   always #5 clock = ~clock;

   router_port_drain #(.STALL_LIMIT(20)) dut (
      .clock       (clock),
      .reset       (reset),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .read_enb    (read_enb),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_sop       (m_sop),
      .m_last      (m_last),
      .pkt_len     (pkt_len),
      .pkt_done    (pkt_done),
      .pkt_err     (pkt_err),
      .pkt_drop    (pkt_drop),
      .dbg_state_o (dbg_state)
   );

   // ---------------- bench state ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] fifo_q[$];     // router FIFO contents
   logic [1:0] tag_q[$];      // 0 header, 1 payload, 2 parity
   logic [9:0] exp_q[$];      // expected {sop, last, data}
   int         hdr_cyc_q[$];
   int         done_cyc_q[$];

   int   ready_mode = 0;      // 0 always ready, 1 toggle, 2 never ready
   logic bus_pay    = 1'b0;
   logic rd_prev    = 1'b0;
   logic occ_chk    = 1'b0;
   int   pushed = 0, popped = 0, occ_viol = 0;
   int   idle_run = 0, max_run = 0;
   int   rx_cnt = 0, extra_cnt = 0, rd_empty = 0;
   int   done_cnt = 0;
   logic last_err = 1'b0, last_drop = 1'b0;
   logic [5:0] last_len = 6'd0;

   // ---------------- scoreboard check ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input logic [7:0] base,
                           input logic corrupt, input logic expect_out);
      logic [7:0] hdr, b, par;
      hdr = {len, addr};
      par = hdr;
      fifo_q.push_back(hdr);
      tag_q.push_back(2'd0);
      b = base;
      for (int i = 0; i < int'(len); i++) begin
         fifo_q.push_back(b);
         tag_q.push_back(2'd1);
         par = par ^ b;
         if (expect_out) exp_q.push_back({(i == 0), (i == int'(len) - 1), b});
         b = b + 8'h11;
      end
      if (corrupt) par = par ^ 8'h01;
      fifo_q.push_back(par);
      tag_q.push_back(2'd2);
   endtask

   // One clock: sample at the falling edge, drive #1 after the rising edge.
   task automatic cycle();
      logic       rd, xfer;
      logic [9:0] e;
      rd   = read_enb;
      xfer = m_valid & m_ready;
      if (occ_chk && rd && tag_q.size() != 0 && tag_q[0] != 2'd0)
         if ((pushed - popped) + (rd_prev ? 1 : 0) >= 2) occ_viol++;
      if (rd && tag_q.size() != 0 && tag_q[0] == 2'd0) hdr_cyc_q.push_back(cyc);
      if (valid_out && !rd) begin
         idle_run++;
         if (idle_run > max_run) max_run = idle_run;
      end else begin
         idle_run = 0;
      end
      if (xfer) begin
         rx_cnt++;
         if (exp_q.size() == 0) extra_cnt++;
         else begin
            e = exp_q.pop_front();
            check_eq("stream_byte", {22'd0, m_sop, m_last, m_data}, {22'd0, e});
         end
      end
      if (pkt_done) begin
         done_cnt++;
         done_cyc_q.push_back(cyc);
         last_err  = pkt_err;
         last_drop = pkt_drop;
         last_len  = pkt_len;
      end
      if (bus_pay) pushed++;
      if (xfer) popped++;
      @(posedge clock);
      #1;
      cyc++;
      bus_pay = 1'b0;
      if (rd) begin
         if (fifo_q.size() != 0) begin
            data_out = fifo_q.pop_front();
            bus_pay  = (tag_q.pop_front() == 2'd1);
         end else begin
            rd_empty++;
         end
      end
      rd_prev = rd;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'b0;
      endcase
      valid_out = (fifo_q.size() != 0);
      @(negedge clock);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         cycle();
         n++;
      end
      check_eq(tag, done_cnt, target);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      int gap;
      reset     = 1'b1;
      valid_out = 1'b0;
      data_out  = 8'd0;
      m_ready   = 1'b1;
      repeat (3) @(negedge clock);

      // Reset state; valid_out high must not leak through to read_enb.
      valid_out = 1'b1;
      #1;
      check_eq("rst_read_enb", read_enb, 0);
      check_eq("rst_m_valid",  m_valid, 0);
      check_eq("rst_m_data",   m_data, 0);
      check_eq("rst_m_sop",    m_sop, 0);
      check_eq("rst_m_last",   m_last, 0);
      check_eq("rst_pkt_len",  pkt_len, 0);
      check_eq("rst_pkt_done", pkt_done, 0);
      check_eq("rst_pkt_err",  pkt_err, 0);
      check_eq("rst_pkt_drop", pkt_drop, 0);
      check_eq("rst_state",    dbg_state, 0);
      valid_out = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      run(2);

      // len=3 A1 B2 C3, good parity (0x0D^A1^B2^C3 = 0xDD)
      rx_cnt = 0;
      d0 = done_cnt;
      send_pkt(6'd3, 2'd1, 8'hA1, 1'b0, 1'b1);
      wait_done("t1_done", d0 + 1, 60);
      check_eq("t1_err",  last_err, 0);
      check_eq("t1_drop", last_drop, 0);
      check_eq("t1_len",  last_len, 3);
      run(4);
      check_eq("t1_rx",   rx_cnt, 3);
      check_eq("t1_left", exp_q.size(), 0);

      // Same packet, parity corrupted
      rx_cnt = 0;
      d0 = done_cnt;
      send_pkt(6'd3, 2'd1, 8'hA1, 1'b1, 1'b1);
      wait_done("t2_done", d0 + 1, 60);
      check_eq("t2_err",  last_err, 1);
      check_eq("t2_drop", last_drop, 0);
      run(4);
      check_eq("t2_rx",   rx_cnt, 3);

      // len=10 with m_ready toggling; read-issue limit watched every read
      rx_cnt     = 0;
      d0         = done_cnt;
      pushed     = 0;
      popped     = 0;
      occ_viol   = 0;
      occ_chk    = 1'b1;
      ready_mode = 1;
      send_pkt(6'd10, 2'd2, 8'h10, 1'b0, 1'b1);
      wait_done("t3_done", d0 + 1, 120);
      run(10);
      occ_chk    = 1'b0;
      ready_mode = 0;
      check_eq("t3_rx",       rx_cnt, 10);
      check_eq("t3_left",     exp_q.size(), 0);
      check_eq("t3_occ_viol", occ_viol, 0);
      check_eq("t3_err",      last_err, 0);

      // m_ready held low: 20 idle cycles, then DROP drains the packet
      d0         = done_cnt;
      max_run    = 0;
      idle_run   = 0;
      extra_cnt  = 0;
      ready_mode = 2;
      send_pkt(6'd8, 2'd3, 8'h40, 1'b0, 1'b0);
      wait_done("t4_done", d0 + 1, 100);
      check_eq("t4_drop",     last_drop, 1);
      check_eq("t4_err",      last_err, 0);
      check_eq("t4_idle_run", max_run, 20);
      check_eq("t4_drained",  fifo_q.size(), 0);
      check_eq("t4_m_valid",  m_valid, 0);
      ready_mode = 0;
      run(4);
      check_eq("t4_extra",    extra_cnt, 0);

      // Two back-to-back len=1 packets
      rx_cnt = 0;
      d0 = done_cnt;
      hdr_cyc_q.delete();
      done_cyc_q.delete();
      send_pkt(6'd1, 2'd0, 8'h5A, 1'b0, 1'b1);
      send_pkt(6'd1, 2'd0, 8'h3C, 1'b0, 1'b1);
      wait_done("t5_done", d0 + 2, 80);
      run(4);
      check_eq("t5_rx",   rx_cnt, 2);
      check_eq("t5_left", exp_q.size(), 0);
      check_eq("t5_hdrs", hdr_cyc_q.size(), 2);
      gap = (hdr_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) ? hdr_cyc_q[1] - done_cyc_q[0] : -1;
      check_eq("t5_hdr_gap", gap, 1);

      // Reset in the middle of a payload
      ready_mode = 2;
      send_pkt(6'd6, 2'd3, 8'h21, 1'b0, 1'b0);
      run(5);
      check_eq("t6_pre_valid", m_valid, 1);
      d0 = done_cnt;
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_m_valid",  m_valid, 0);
      check_eq("t6_read_enb", read_enb, 0);
      check_eq("t6_pkt_len",  pkt_len, 0);
      check_eq("t6_state",    dbg_state, 0);
      fifo_q.delete();
      tag_q.delete();
      valid_out = 1'b0;
      data_out  = 8'd0;
      bus_pay   = 1'b0;
      rd_prev   = 1'b0;
      run(2);
      reset = 1'b0;
      run(3);
      check_eq("t6_no_done", done_cnt, d0);
      ready_mode = 0;
      rx_cnt = 0;
      send_pkt(6'd2, 2'd0, 8'h77, 1'b0, 1'b1);
      wait_done("t6_done", d0 + 1, 60);
      check_eq("t6_len",  last_len, 2);
      check_eq("t6_err",  last_err, 0);
      check_eq("t6_drop", last_drop, 0);
      run(4);
      check_eq("t6_rx",   rx_cnt, 2);

      check_eq("read_from_empty", rd_empty, 0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
